// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Key constants and state type shared by the keycode front end and the
// game-control FSM. Also holds the saturating counter helper used by the
// debounce and repeat counters.
// Ports: none (package).
// ---------------------------------------------------------------------------
package game_pkg;

  // USB HID usage codes for the keys the game reacts to
  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_P     = 8'h13;
  localparam logic [7:0] KEY_M     = 8'h10;
  localparam logic [7:0] KEY_W     = 8'h1A;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    HELD,
    RELEASE
  } kev_state_t;

  // Counters stop at all-ones instead of wrapping, so a very long hold can
  // never alias back onto a terminal count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/keycode_event_gen_if.sv
// ---------------------------------------------------------------------------
// keycode_event_gen_if
// Groups the raw keycode input with the event/level outputs of the keycode
// front end.
//   keycode       : raw PIO keycode, 8'h00 = no key
//   key_evt       : accepted keycode for one cycle per press/repeat
//   key_evt_valid : qualifies key_evt
//   key_held      : currently accepted held key
//   *_pulse       : decoded single-cycle action requests
//   jump_held     : level, W is the accepted held key
// Modports: master = keycode source / event consumer, slave = front end.
// ---------------------------------------------------------------------------
interface keycode_event_gen_if;

  logic [7:0] keycode;
  logic [7:0] key_evt;
  logic       key_evt_valid;
  logic [7:0] key_held;
  logic       start_pulse;
  logic       pause_pulse;
  logic       menu_pulse;
  logic       jump_pulse;
  logic       jump_held;

  modport master (
    output keycode,
    input  key_evt, key_evt_valid, key_held,
    input  start_pulse, pause_pulse, menu_pulse, jump_pulse, jump_held
  );

  modport slave (
    input  keycode,
    output key_evt, key_evt_valid, key_held,
    output start_pulse, pause_pulse, menu_pulse, jump_pulse, jump_held
  );

endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a bus of slowly changing PIO bits. Individual
// bits may land a cycle apart; the downstream debounce absorbs that skew.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : second-stage (synchronized) value
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keycode_event_gen.sv
// ---------------------------------------------------------------------------
// keycode_event_gen
// Turns the raw, asynchronous USB keycode into debounced single-cycle key
// events, optional auto-repeat events, decoded action pulses and a held-key
// level for the game-control logic.
//   Clk   : system clock
//   Reset : asynchronous active-high reset
//   kev   : keycode in, key_evt/key_evt_valid/key_held/action pulses/
//           jump_held out (all outputs registered)
// Parameters:
//   STABLE_CYCLES : cycles a keycode (or release) must be stable, 2..65535
//   REPEAT_CYCLES : cycles between repeat events while held, 0 = no repeat
// ---------------------------------------------------------------------------
module keycode_event_gen
  import game_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  keycode_event_gen_if.slave  kev
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST =
    CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam bit               REPEAT_EN   = (REPEAT_CYCLES != 0);

  logic [7:0] sync;

  kev_state_t       state_q, state_d;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rpt_q, rpt_d;

  logic [7:0] key_evt_q, key_evt_d;
  logic       key_evt_valid_q, key_evt_valid_d;
  logic [7:0] key_held_q, key_held_d;
  logic       start_pulse_q, start_pulse_d;
  logic       pause_pulse_q, pause_pulse_d;
  logic       menu_pulse_q, menu_pulse_d;
  logic       jump_pulse_q, jump_pulse_d;
  logic       jump_held_q, jump_held_d;

  sync_2ff #(
    .WIDTH (8)
  ) u_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (kev.keycode),
    .q   (sync)
  );

  // Next-state logic. cnt measures stability of cand (DEBOUNCE) or of the
  // released keyboard (RELEASE); rpt paces auto-repeat while HELD.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;

    case (state_q)
      IDLE: begin
        if (sync != KEY_NONE) begin
          state_d = DEBOUNCE;
          cand_d  = sync;
          cnt_d   = '0;
        end
      end

      DEBOUNCE: begin
        if (sync == KEY_NONE) begin
          state_d = IDLE;
        end else if (sync == cand_q) begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_q == STABLE_LAST) begin
            state_d = PRESSED;
          end
        end else begin
          cand_d = sync;
          cnt_d  = '0;
        end
      end

      PRESSED: begin
        state_d = HELD;
        rpt_d   = '0;
      end

      // Release and key change are checked before the repeat tick so a
      // repeat can never fire for a key that has already gone away.
      HELD: begin
        if (sync == KEY_NONE) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (sync != cand_q) begin
          state_d = DEBOUNCE;
          cand_d  = sync;
          cnt_d   = '0;
        end else if (REPEAT_EN && (rpt_q == REPEAT_LAST)) begin
          state_d = PRESSED;
        end else begin
          rpt_d = sat_inc(rpt_q);
        end
      end

      // A bounce back to the same key resumes holding without a new event.
      RELEASE: begin
        if (sync == KEY_NONE) begin
          cnt_d = sat_inc(cnt_q);
          if (cnt_q == STABLE_LAST) begin
            state_d = IDLE;
          end
        end else if (sync == cand_q) begin
          state_d = HELD;
          rpt_d   = '0;
        end else begin
          state_d = DEBOUNCE;
          cand_d  = sync;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered outputs line
  // up with the state they describe instead of trailing it by a cycle.
  always_comb begin
    key_evt_d       = KEY_NONE;
    key_evt_valid_d = 1'b0;
    key_held_d      = KEY_NONE;

    if (state_d == PRESSED) begin
      key_evt_d       = cand_d;
      key_evt_valid_d = 1'b1;
    end

    if ((state_d == PRESSED) || (state_d == HELD) || (state_d == RELEASE)) begin
      key_held_d = cand_d;
    end

    start_pulse_d = key_evt_valid_d && (cand_d == KEY_SPACE);
    pause_pulse_d = key_evt_valid_d && (cand_d == KEY_P);
    menu_pulse_d  = key_evt_valid_d && (cand_d == KEY_M);
    jump_pulse_d  = key_evt_valid_d && (cand_d == KEY_W);
    jump_held_d   = (key_held_d == KEY_W);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= IDLE;
      cand_q          <= KEY_NONE;
      cnt_q           <= '0;
      rpt_q           <= '0;
      key_evt_q       <= KEY_NONE;
      key_evt_valid_q <= 1'b0;
      key_held_q      <= KEY_NONE;
      start_pulse_q   <= 1'b0;
      pause_pulse_q   <= 1'b0;
      menu_pulse_q    <= 1'b0;
      jump_pulse_q    <= 1'b0;
      jump_held_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cand_q          <= cand_d;
      cnt_q           <= cnt_d;
      rpt_q           <= rpt_d;
      key_evt_q       <= key_evt_d;
      key_evt_valid_q <= key_evt_valid_d;
      key_held_q      <= key_held_d;
      start_pulse_q   <= start_pulse_d;
      pause_pulse_q   <= pause_pulse_d;
      menu_pulse_q    <= menu_pulse_d;
      jump_pulse_q    <= jump_pulse_d;
      jump_held_q     <= jump_held_d;
    end
  end

  assign kev.key_evt       = key_evt_q;
  assign kev.key_evt_valid = key_evt_valid_q;
  assign kev.key_held      = key_held_q;
  assign kev.start_pulse   = start_pulse_q;
  assign kev.pause_pulse   = pause_pulse_q;
  assign kev.menu_pulse    = menu_pulse_q;
  assign kev.jump_pulse    = jump_pulse_q;
  assign kev.jump_held     = jump_held_q;

endmodule

// File: tb/tb_keycode_event_gen.sv
// ---------------------------------------------------------------------------
// tb_keycode_event_gen
// Two instances share clock and reset: dut_a without auto-repeat and dut_b
// with REPEAT_CYCLES=8, both with STABLE_CYCLES=4. Expected events are
// queued when a keycode is driven and consumed by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_keycode_event_gen;

  localparam int S   = 4;
  localparam int R_B = 8;

  typedef struct {
    logic [7:0] code;
    int         due;
  } evt_t;

  typedef struct {
    logic [7:0] code;
    int         hold;
    bit         expect_evt;
    logic [7:0] exp_held;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_pass;

  evt_t exp_a[$];
  evt_t exp_b[$];
  vec_t vecs[7];

  keycode_event_gen_if kev_a ();
  keycode_event_gen_if kev_b ();

  keycode_event_gen #(
    .STABLE_CYCLES (S),
    .REPEAT_CYCLES (0)
  ) dut_a (
    .Clk   (clk),
    .Reset (reset),
    .kev   (kev_a)
  );

  keycode_event_gen #(
    .STABLE_CYCLES (S),
    .REPEAT_CYCLES (R_B)
  ) dut_b (
    .Clk   (clk),
    .Reset (reset),
    .kev   (kev_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] expPulses(input logic [7:0] code);
    return {code == 8'h2C, code == 8'h13, code == 8'h10, code == 8'h1A};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Drives a keycode at the current time (2 time units after an edge) and
  // queues the events it should cause: first event S+3 edges later, then one
  // every R+1 edges while the key is still visible to the state machine.
  task automatic applyStimulus(input bit to_b, input logic [7:0] code,
                               input int hold, input bit expect_evt);
    int k;
    int t;
    evt_t e;
    k = cyc;
    if (to_b) kev_b.keycode = code;
    else      kev_a.keycode = code;
    if (expect_evt) begin
      t = S + 3;
      while (t - 2 <= hold) begin
        e.code = code;
        e.due  = k + t;
        if (to_b) exp_b.push_back(e);
        else      exp_a.push_back(e);
        if (!to_b) break;
        t += R_B + 1;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic monitorPort(input int port, input logic [7:0] evt, input logic valid,
                             input logic [3:0] pulses);
    evt_t e;
    bit   have;
    have = 1'b0;
    if (valid) begin
      if (port == 0 && exp_a.size() > 0) begin
        e = exp_a.pop_front();
        have = 1'b1;
      end else if (port == 1 && exp_b.size() > 0) begin
        e = exp_b.pop_front();
        have = 1'b1;
      end
      if (!have) begin
        n_checks++;
        $display("[TB] FAIL unexpected_evt port%0d: got key_evt=%0h at cycle %0d, expected no event",
                 port, evt, cyc);
      end else begin
        checkOutput($sformatf("evt_code_p%0d", port), int'(evt), int'(e.code));
        checkOutput($sformatf("evt_cycle_p%0d", port), cyc, e.due);
        checkOutput($sformatf("evt_pulses_p%0d", port), int'(pulses), int'(expPulses(e.code)));
      end
    end else if (evt != 8'h00 || pulses != 4'b0000) begin
      n_checks++;
      $display("[TB] FAIL spurious_out port%0d: got key_evt=%0h pulses=%b without valid, expected 0",
               port, evt, pulses);
    end
  endtask

  always @(negedge clk) begin
    monitorPort(0, kev_a.key_evt, kev_a.key_evt_valid,
                {kev_a.start_pulse, kev_a.pause_pulse, kev_a.menu_pulse, kev_a.jump_pulse});
    monitorPort(1, kev_b.key_evt, kev_b.key_evt_valid,
                {kev_b.start_pulse, kev_b.pause_pulse, kev_b.menu_pulse, kev_b.jump_pulse});
  end

  function automatic int outsA();
    return int'({kev_a.key_evt, kev_a.key_evt_valid, kev_a.key_held, kev_a.start_pulse,
                 kev_a.pause_pulse, kev_a.menu_pulse, kev_a.jump_pulse, kev_a.jump_held});
  endfunction

  function automatic int outsB();
    return int'({kev_b.key_evt, kev_b.key_evt_valid, kev_b.key_held, kev_b.start_pulse,
                 kev_b.pause_pulse, kev_b.menu_pulse, kev_b.jump_pulse, kev_b.jump_held});
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    kev_a.keycode = 8'h00;
    kev_b.keycode = 8'h00;

    vecs[0] = '{code: 8'h13, hold: 20, expect_evt: 1'b1, exp_held: 8'h13};
    vecs[1] = '{code: 8'h1A, hold: 2,  expect_evt: 1'b0, exp_held: 8'h00};
    vecs[2] = '{code: 8'h1A, hold: S,  expect_evt: 1'b0, exp_held: 8'h00};
    vecs[3] = '{code: 8'h1A, hold: S+1, expect_evt: 1'b1, exp_held: 8'h1A};
    vecs[4] = '{code: 8'h2C, hold: 10, expect_evt: 1'b1, exp_held: 8'h2C};
    vecs[5] = '{code: 8'h10, hold: 10, expect_evt: 1'b1, exp_held: 8'h10};
    vecs[6] = '{code: 8'h55, hold: 10, expect_evt: 1'b1, exp_held: 8'h55};

    tick(3);
    checkOutput("reset_outputs_a", outsA(), 0);
    checkOutput("reset_outputs_b", outsB(), 0);
    reset = 1'b0;
    tick(3);

    // Table-driven presses on the non-repeating instance
    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b0, vecs[v].code, vecs[v].hold, vecs[v].expect_evt);
      for (int c = 1; c <= vecs[v].hold + 14; c++) begin
        tick(1);
        if (c == vecs[v].hold) kev_a.keycode = 8'h00;
        if (c == S + 2) checkOutput($sformatf("v%0d_held_pre", v), int'(kev_a.key_held), 0);
        if (c == S + 3) begin
          checkOutput($sformatf("v%0d_valid", v), int'(kev_a.key_evt_valid), int'(vecs[v].expect_evt));
          checkOutput($sformatf("v%0d_held", v), int'(kev_a.key_held), int'(vecs[v].exp_held));
        end
      end
      checkOutput($sformatf("v%0d_released", v), int'(kev_a.key_held), 0);
    end

    // Change while held: space, then directly M
    applyStimulus(1'b0, 8'h2C, 12, 1'b1);
    tick(12);
    checkOutput("chg_held_space", int'(kev_a.key_held), 8'h2C);
    applyStimulus(1'b0, 8'h10, 20, 1'b1);
    for (int c = 1; c <= 34; c++) begin
      tick(1);
      if (c == 20) kev_a.keycode = 8'h00;
      if (c == 2) checkOutput("chg_held_before", int'(kev_a.key_held), 8'h2C);
      if (c == 5) checkOutput("chg_held_rebounce", int'(kev_a.key_held), 8'h00);
      if (c == 7) checkOutput("chg_held_menu", int'(kev_a.key_held), 8'h10);
    end
    checkOutput("chg_released", int'(kev_a.key_held), 0);

    // Release bounce: W, two cycles of 0, W again
    applyStimulus(1'b0, 8'h1A, 12, 1'b1);
    for (int c = 1; c <= 38; c++) begin
      tick(1);
      if (c == 12) kev_a.keycode = 8'h00;
      if (c == 14) kev_a.keycode = 8'h1A;
      if (c == 24) kev_a.keycode = 8'h00;
      if (c >= 15 && c <= 17) checkOutput($sformatf("bounce_jump_held_c%0d", c),
                                          int'(kev_a.jump_held), 1);
    end
    checkOutput("bounce_jump_released", int'(kev_a.jump_held), 0);

    // Auto-repeat on dut_b: W held 40 cycles, release beats the 5th tick
    applyStimulus(1'b1, 8'h1A, 40, 1'b1);
    for (int c = 1; c <= 54; c++) begin
      tick(1);
      if (c == 40) kev_b.keycode = 8'h00;
      if (c == 20) checkOutput("rpt_jump_held", int'(kev_b.jump_held), 1);
    end
    checkOutput("rpt_released", int'(kev_b.key_held), 0);

    // Asynchronous reset while PRESSED, key still down afterwards
    applyStimulus(1'b0, 8'h13, 30, 1'b1);
    tick(S + 3);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_outputs", outsA(), 0);
    tick(2);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h13, 20, 1'b1);
    tick(20);
    checkOutput("post_reset_held", int'(kev_a.key_held), 8'h13);
    kev_a.keycode = 8'h00;
    tick(14);
    checkOutput("post_reset_released", int'(kev_a.key_held), 0);

    checkOutput("pending_events_a", exp_a.size(), 0);
    checkOutput("pending_events_b", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
